// File: rtl/bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD conversion engine.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam int ACC_MAX = 64;

  function automatic int bcd_width(input int w);
    return w + (w - 4) / 3 + 1;
  endfunction

  // Double-dabble correction: any BCD digit above 4 gets +3 before the shift.
  function automatic logic [ACC_MAX-1:0] add3_nibbles(input logic [ACC_MAX-1:0] acc);
    logic [ACC_MAX-1:0] r;
    r = acc;
    for (int n = 0; n < ACC_MAX / 4; n++) begin
      if (acc[n*4 +: 4] > 4'd4) r[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above the pointer, wrapping.
module rr_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDW   = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  input  logic [IDW-1:0]   pointer,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx
);

  int   i;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    i     = 0;
    if (enable) begin
      for (int k = 0; k < N_REQ; k++) begin
        i = (int'(pointer) + k) % N_REQ;
        if (!found && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Shared multi-cycle binary-to-BCD converter (double dabble, one bit per clock)
// fronted by a round-robin arbiter; results are tagged with the requester index.
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int W     = 11,
  parameter int N_REQ = 2,
  localparam int BW   = bcd_width(W),
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_bin,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [BW-1:0]      out_bcd,
  output logic [IDW-1:0]     out_id,
  input  logic               out_ready,
  output logic               busy
);

  localparam int ACCW = 4 * ((BW + 3) / 4);
  localparam int CW   = $clog2(W + 1);

  state_t             state;
  logic [W-1:0]       shift;
  logic [ACCW-1:0]    acc;
  logic [CW-1:0]      cnt;
  logic [IDW-1:0]     ptr;
  logic [N_REQ-1:0]   grant;
  logic [IDW-1:0]     gidx;
  logic [ACC_MAX-1:0] acc_wide;
  logic [ACC_MAX-1:0] acc_fix;
  logic [ACCW-1:0]    acc_next;
  logic               unused_fix;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .enable ((state == IDLE) && !rst),
    .pointer(ptr),
    .grant  (grant),
    .idx    (gidx)
  );

  assign req_ready  = grant;
  assign acc_wide   = ACC_MAX'(acc);
  assign acc_fix    = add3_nibbles(acc_wide);
  assign acc_next   = {acc_fix[ACCW-2:0], shift[W-1]};
  // Bits above the accumulator width are always zero after correction.
  assign unused_fix = ^acc_fix[ACC_MAX-1:ACCW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_bcd   <= '0;
      out_id    <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            shift  <= req_bin[int'(gidx)*W +: W];
            acc    <= '0;
            out_id <= gidx;
            cnt    <= CW'(W);
            ptr    <= (gidx == IDW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          // Counter hits zero after W shifts; the extra cycle publishes the result.
          if (cnt == '0) begin
            out_bcd   <= acc[BW-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc   <= acc_next;
            shift <= {shift[W-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for the shared BCD converter: reset, latency, arbitration, backpressure, abort.
module tb_bcd_conv_sched;

  localparam int W  = 11;
  localparam int N  = 2;
  localparam int BW = 14;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_bin;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [BW-1:0]  out_bcd;
  logic [0:0]     out_id;
  logic           out_ready;
  logic           busy;

  int tests = 0;
  int fails = 0;

  bcd_conv_sched #(.W(W), .N_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_bin  (req_bin),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_bcd  (out_bcd),
    .out_id   (out_id),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [BW-1:0] ref_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r[BW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [W-1:0] v);
    req_bin[id*W +: W] = v;
    req_valid[id]      = 1'b1;
    tick();
    req_valid[id]      = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    req_bin   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (out_bcd !== 14'h0000) begin fails++; $display("FAIL reset_out_bcd got %h want 0000", out_bcd); end
    tests++; if (out_id !== 1'b0) begin fails++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    req_bin[W-1:0] = 11'd2047;
    req_valid      = 2'b01;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL basic_req_ready got %b want 01", req_ready); end
    tick();
    req_valid = '0;
    wait_valid(n);
    tests++; if (n != 12) begin fails++; $display("FAIL basic_latency got %0d want 12", n); end
    tests++; if (out_bcd !== 14'h2047) begin fails++; $display("FAIL basic_bcd got %h want 2047", out_bcd); end
    tests++; if (out_id !== 1'b0) begin fails++; $display("FAIL basic_id got %0d want 0", out_id); end
    pop();
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_idle got busy=%b valid=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_values();
    int n;
    issue(0, 11'd0);
    wait_valid(n);
    tests++; if (out_bcd !== 14'h0000) begin fails++; $display("FAIL zero_bcd got %h want 0000", out_bcd); end
    pop();
    issue(1, 11'd999);
    wait_valid(n);
    tests++; if (out_bcd !== 14'h0999 || out_id !== 1'b1) begin fails++; $display("FAIL v999 got %h id %0d want 0999 id 1", out_bcd, out_id); end
    pop();
  endtask

  task automatic test_sweep();
    int n;
    for (int v = 0; v < 2048; v++) begin
      issue(v & 1, 11'(v));
      wait_valid(n);
      tests++;
      if (n != 12 || out_bcd !== ref_bcd(v) || out_id !== 1'(v & 1)) begin
        fails++;
        $display("FAIL sweep v=%0d got %h id %0d lat %0d want %h id %0d lat 12", v, out_bcd, out_id, n, ref_bcd(v), v & 1);
      end
      pop();
    end
  endtask

  task automatic test_two_req();
    int n;
    do_reset();
    req_bin   = {11'd13, 11'd5};
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rr_first got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL rr_conv_ready got %b want 00", req_ready); end
    wait_valid(n);
    tests++; if (out_bcd !== 14'h0005 || out_id !== 1'b0) begin fails++; $display("FAIL rr_res0 got %h id %0d want 0005 id 0", out_bcd, out_id); end
    pop();
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL rr_second got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_valid(n);
    tests++; if (out_bcd !== 14'h0013 || out_id !== 1'b1) begin fails++; $display("FAIL rr_res1 got %h id %0d want 0013 id 1", out_bcd, out_id); end
    pop();
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rr_wrap got %b want 01", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    issue(1, 11'd321);
    wait_valid(n);
    bad = 0;
    req_valid = 2'b11;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_valid !== 1'b1 || out_bcd !== 14'h0321 || out_id !== 1'b1 || req_ready !== 2'b00 || busy !== 1'b1) bad++;
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    req_valid = 2'b00;
    pop();
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hold_release got valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    req_bin[2*W-1:W] = 11'd77;
    req_valid        = 2'b10;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL abort_idle got busy=%b valid=%b want 0 0", busy, out_valid); end
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL abort_ptr got %b want 01", req_ready); end
    req_valid = 2'b10;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL abort_regrant got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_valid(n);
    tests++; if (n != 12 || out_bcd !== 14'h0077 || out_id !== 1'b1) begin fails++; $display("FAIL abort_result got %h id %0d lat %0d want 0077 id 1 lat 12", out_bcd, out_id, n); end
    pop();
  endtask

  task automatic test_pulse_busy();
    int n;
    int bad;
    issue(0, 11'd42);
    tick();
    tick();
    req_bin[2*W-1:W] = 11'd99;
    req_valid        = 2'b10;
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL pulse_ready got %b want 00", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_valid(n);
    tests++; if (out_bcd !== 14'h0042 || out_id !== 1'b0) begin fails++; $display("FAIL pulse_result got %h id %0d want 0042 id 0", out_bcd, out_id); end
    pop();
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL pulse_no_grant got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_bin   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_values();
    test_two_req();
    test_backpressure();
    test_reset_mid();
    test_pulse_busy();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
